// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one single-port SRAM between the CPU MEM stage and an
// external requester, with CPU priority bounded by a starvation limit for the external port.
module dm_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_web,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_di,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              ext_req,
  input  logic [3:0]        ext_web,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_di,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata,
  output logic              sram_CS,
  output logic              sram_OE,
  output logic [3:0]        sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [31:0]       sram_DI,
  input  logic [31:0]       sram_DO
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WR, EXT_RD, EXT_WR} state_t;
  typedef enum logic [1:0] {W_NONE, W_CPU, W_EXT} win_t;

  state_t      state;
  state_t      state_nxt;
  win_t        win;
  logic [3:0]  starve_cnt;
  logic        force_ext;
  logic [31:0] cpu_rdata_q;
  logic [31:0] ext_rdata_q;

  always_comb begin
    force_ext = ext_req && (starve_cnt == STARVE_LIM);
    win       = W_NONE;
    if (force_ext)    win = W_EXT;
    else if (cpu_req) win = W_CPU;
    else if (ext_req) win = W_EXT;

    sram_CS   = 1'b0;
    sram_WEB  = '1;
    sram_A    = '0;
    sram_DI   = '0;
    state_nxt = IDLE;
    case (win)
      W_CPU: begin
        sram_CS   = 1'b1;
        sram_WEB  = cpu_web;
        sram_A    = cpu_addr;
        sram_DI   = cpu_di;
        state_nxt = (cpu_web == 4'hF) ? CPU_RD : CPU_WR;
      end
      W_EXT: begin
        sram_CS   = 1'b1;
        sram_WEB  = ext_web;
        sram_A    = ext_addr;
        sram_DI   = ext_di;
        state_nxt = (ext_web == 4'hF) ? EXT_RD : EXT_WR;
      end
      default: ;
    endcase
    sram_OE   = sram_CS && (sram_WEB == 4'hF);
    cpu_stall = cpu_req && (win != W_CPU);
    ext_gnt   = (win == W_EXT);
  end

  // Read data is only valid on sram_DO in the cycle after the access, so it is passed
  // through while the owner state says so and held in a register afterwards.
  assign cpu_rvalid = (state == CPU_RD);
  assign ext_rvalid = (state == EXT_RD);
  assign cpu_rdata  = cpu_rvalid ? sram_DO : cpu_rdata_q;
  assign ext_rdata  = ext_rvalid ? sram_DO : ext_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (ext_req && (win == W_CPU)) begin
        if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
      if (cpu_rvalid) cpu_rdata_q <= sram_DO;
      if (ext_rvalid) ext_rdata_q <= sram_DO;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural single-port SRAM (1-cycle read latency).
module tb_dm_port_arbiter;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [3:0]        cpu_web;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_di;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              ext_req;
  logic [3:0]        ext_web;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_di;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [31:0]       ext_rdata;
  logic              sram_CS;
  logic              sram_OE;
  logic [3:0]        sram_WEB;
  logic [ADDR_W-1:0] sram_A;
  logic [31:0]       sram_DI;
  logic [31:0]       sram_DO;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_web(cpu_web), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_web(ext_web), .ext_addr(ext_addr), .ext_di(ext_di),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .sram_CS(sram_CS), .sram_OE(sram_OE), .sram_WEB(sram_WEB), .sram_A(sram_A),
    .sram_DI(sram_DI), .sram_DO(sram_DO)
  );

  always @(posedge clk) begin
    if (sram_CS) begin
      for (int b = 0; b < 4; b++)
        if (!sram_WEB[b]) mem[sram_A][8*b +: 8] <= sram_DI[8*b +: 8];
      if (sram_OE) sram_DO <= mem[sram_A];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_web = 4'hF; cpu_addr = '0; cpu_di = '0;
    ext_req = 1'b0; ext_web = 4'hF; ext_addr = '0; ext_di = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic cpu_access(input logic [3:0] web, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d);
    cpu_req = 1'b1; cpu_web = web; cpu_addr = a; cpu_di = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    tests_run++;
    if ({sram_CS, sram_OE, sram_WEB, cpu_stall, ext_gnt, cpu_rvalid, ext_rvalid} !== 9'b0_0_1111_0_0_0_0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got CS=%b OE=%b WEB=%h stall=%b gnt=%b rv=%b/%b expected 0 0 f 0 0 0/0",
               sram_CS, sram_OE, sram_WEB, cpu_stall, ext_gnt, cpu_rvalid, ext_rvalid);
    end
    tests_run++;
    if ({sram_A, sram_DI, cpu_rdata, ext_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got A=%h DI=%h crd=%h erd=%h expected all 0",
               sram_A, sram_DI, cpu_rdata, ext_rdata);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_cpu_alone();
    cpu_access(4'h0, 14'h10, 32'hDEADBEEF);
    @(negedge clk);
    tests_run++;
    if ({sram_CS, sram_OE, sram_WEB, cpu_stall} !== 7'b1_0_0000_0) begin
      tests_failed++;
      $display("FAIL cpu_write_drive: got CS=%b OE=%b WEB=%h stall=%b expected 1 0 0 0",
               sram_CS, sram_OE, sram_WEB, cpu_stall);
    end
    step();
    cpu_access(4'hF, 14'h10, 32'h0);
    @(negedge clk);
    tests_run++;
    if ({sram_CS, sram_OE, sram_WEB, cpu_stall, cpu_rvalid, sram_A} !== {8'b1_1_1111_0_0, 14'h10}) begin
      tests_failed++;
      $display("FAIL cpu_read_drive: got CS=%b OE=%b WEB=%h stall=%b rv=%b A=%h expected 1 1 f 0 0 010",
               sram_CS, sram_OE, sram_WEB, cpu_stall, cpu_rvalid, sram_A);
    end
    step();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || ext_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL cpu_read_return: got rv=%b rdata=%h erv=%b expected 1 deadbeef 0",
               cpu_rvalid, cpu_rdata, ext_rvalid);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL cpu_read_hold: got rv=%b rdata=%h expected 0 deadbeef", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_starvation();
    apply_reset();
    cpu_access(4'hF, 14'h20, 32'h0);
    ext_req = 1'b1; ext_web = 4'h0; ext_addr = 14'h30; ext_di = 32'h5A5A5A5A;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (ext_gnt !== (k % 5 == 0) || cpu_stall !== (k % 5 == 0) ||
          dut.starve_cnt !== 4'((k - 1) % 5)) begin
        tests_failed++;
        $display("FAIL starve_cycle%0d: got gnt=%b stall=%b cnt=%0d expected gnt=%b stall=%b cnt=%0d",
                 k, ext_gnt, cpu_stall, dut.starve_cnt, (k % 5 == 0), (k % 5 == 0), (k - 1) % 5);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_interleaved();
    cpu_access(4'h0, 14'h1, 32'h1111_0001);
    step();
    cpu_access(4'h0, 14'h2, 32'h2222_0002);
    step();
    cpu_access(4'hF, 14'h1, 32'h0);
    step();
    cpu_req = 1'b0;
    ext_req = 1'b1; ext_web = 4'hF; ext_addr = 14'h2;
    @(negedge clk);
    tests_run++;
    if (ext_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1111_0001 || ext_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ilv_cpu_return: got gnt=%b crv=%b crd=%h erv=%b expected 1 1 11110001 0",
               ext_gnt, cpu_rvalid, cpu_rdata, ext_rvalid);
    end
    step();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h2222_0002 || cpu_rvalid !== 1'b0 ||
        cpu_rdata !== 32'h1111_0001) begin
      tests_failed++;
      $display("FAIL ilv_ext_return: got erv=%b erd=%h crv=%b crd=%h expected 1 22220002 0 11110001",
               ext_rvalid, ext_rdata, cpu_rvalid, cpu_rdata);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (ext_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || ext_rdata !== 32'h2222_0002 ||
        cpu_rdata !== 32'h1111_0001) begin
      tests_failed++;
      $display("FAIL ilv_hold: got erv=%b erd=%h crv=%b crd=%h expected 0 22220002 0 11110001",
               ext_rvalid, ext_rdata, cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_byte_write();
    cpu_access(4'h0, 14'h5, 32'h11223344);
    step();
    cpu_access(4'b1110, 14'h5, 32'h000000AA);
    step();
    cpu_access(4'hF, 14'h5, 32'h0);
    step();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h112233AA) begin
      tests_failed++;
      $display("FAIL byte_write: got rv=%b rdata=%h expected 1 112233aa", cpu_rvalid, cpu_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    cpu_access(4'hF, 14'h1, 32'h0);
    step();
    #2;
    idle_inputs();
    rst = 1'b1;
    #1;
    tests_run++;
    if (sram_CS !== 1'b0 || sram_WEB !== 4'hF || cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0 ||
        cpu_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_read: got CS=%b WEB=%h crv=%b erv=%b crd=%h expected 0 f 0 0 0",
               sram_CS, sram_WEB, cpu_rvalid, ext_rvalid, cpu_rdata);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL no_stale_rvalid%0d: got crv=%b erv=%b expected 0 0", k, cpu_rvalid, ext_rvalid);
      end
      step();
    end
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (sram_CS !== 1'b0 || cpu_stall !== 1'b0 || ext_gnt !== 1'b0 || dut.starve_cnt !== 4'd0) begin
        tests_failed++;
        $display("FAIL idle%0d: got CS=%b stall=%b gnt=%b cnt=%0d expected 0 0 0 0",
                 k, sram_CS, cpu_stall, ext_gnt, dut.starve_cnt);
      end
      step();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #2;
    test_reset();
    test_cpu_alone();
    test_starvation();
    test_interleaved();
    test_byte_write();
    test_reset_mid_read();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
